// File: rtl/io_bus_master.sv
// io_bus_master: single-outstanding initiator for the local 8-bit-address I/O space.
// It takes read/write commands on a valid/ready port and drives addr/wdata/we to the I/O block.
// It samples the block's combinational read data and returns one response per command.
// Sequence per command: IDLE -> ACCESS (1 + WAIT_CYCLES cycles) -> RESP (until consumed) -> IDLE.

module io_bus_master #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // Command channel
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    // Response channel
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    // I/O block side
    output logic [ADDR_W-1:0] o_io_addr,
    output logic [DATA_W-1:0] o_io_wdata,
    output logic              o_io_we,
    input  logic [DATA_W-1:0] i_io_rdata,
    // Status
    output logic              o_busy
);

    // The wait counter is 4 bits wide, so longer waits cannot be represented.
    if (WAIT_CYCLES > 15) begin : g_wait_range_check
        $error("io_bus_master: WAIT_CYCLES must be in the range 0..15");
    end

    localparam logic [3:0] WaitInit = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // State and registered outputs
    state_e              r_state;
    logic [3:0]          r_wait_cnt;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_io_addr;
    logic [DATA_W-1:0]   r_io_wdata;
    logic                r_io_we;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

    // Next-state values
    state_e              w_state_nxt;
    logic [3:0]          w_wait_cnt_nxt;
    logic                w_is_write_nxt;
    logic [ADDR_W-1:0]   w_io_addr_nxt;
    logic [DATA_W-1:0]   w_io_wdata_nxt;
    logic                w_io_we_nxt;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;

    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_last_access;

    // Ready is gated by reset so nothing can be accepted while reset is held.
    assign w_cmd_ready   = (r_state == StIdle) && !i_reset;
    assign w_accept      = w_cmd_ready && i_cmd_valid;
    assign w_last_access = (r_wait_cnt == 4'd0);

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_is_write_nxt  = r_is_write;
        w_io_addr_nxt   = r_io_addr;
        w_io_wdata_nxt  = r_io_wdata;
        w_io_we_nxt     = 1'b0;      // write strobe lasts one cycle unless re-armed on accept
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_io_addr_nxt  = i_cmd_addr;
                    w_io_wdata_nxt = i_cmd_wdata;
                    w_is_write_nxt = i_cmd_we;
                    w_io_we_nxt    = i_cmd_we;
                    w_wait_cnt_nxt = WaitInit;
                    w_state_nxt    = StAccess;
                end
            end

            StAccess: begin
                if (w_last_access) begin
                    // Read data is only trusted at the end of the final access cycle.
                    w_rsp_rdata_nxt = r_is_write ? '0 : i_io_rdata;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = StResp;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end

            StResp: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = StIdle;
                end
            end

            default: begin
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = StIdle;
            end
        endcase
    end

    // State and output registers; async reset discards any in-flight command.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_wait_cnt  <= 4'd0;
            r_is_write  <= 1'b0;
            r_io_addr   <= '0;
            r_io_wdata  <= '0;
            r_io_we     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_is_write  <= w_is_write_nxt;
            r_io_addr   <= w_io_addr_nxt;
            r_io_wdata  <= w_io_wdata_nxt;
            r_io_we     <= w_io_we_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign o_cmd_ready = w_cmd_ready;
    assign o_busy      = (r_state != StIdle);
    assign o_io_addr   = r_io_addr;
    assign o_io_wdata  = r_io_wdata;
    assign o_io_we     = r_io_we;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;

endmodule
